// File: rtl/touch_scan_ctrl_pkg.sv
// Shared types for the touch scan path: key codes, FSM state encoding and
// the helpers that classify and decode a 4-pad vector.
package touch_pkg;

  typedef logic [3:0] code_t;

  localparam code_t CODE_NONE = 4'd0;
  localparam code_t CODE_S1   = 4'd1;
  localparam code_t CODE_S2   = 4'd2;
  localparam code_t CODE_S3   = 4'd3;
  localparam code_t CODE_S4   = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_MULTI  = 2'd2
  } touch_state_e;

  // One-hot pad vector to key code; anything else decodes to "none".
  function automatic code_t onehot_to_code(input logic [3:0] v);
    case (v)
      4'b0001: return CODE_S1;
      4'b0010: return CODE_S2;
      4'b0100: return CODE_S3;
      4'b1000: return CODE_S4;
      default: return CODE_NONE;
    endcase
  endfunction

  // Touch state implied by a pad vector.
  function automatic touch_state_e classify(input logic [3:0] v);
    if (v == 4'b0000)
      return ST_IDLE;
    else if ((v & (v - 4'd1)) == 4'b0000)
      return ST_SINGLE;
    else
      return ST_MULTI;
  endfunction

endpackage

// File: rtl/touch_scan_ctrl_if.sv
// Press/release event channel between the scan controller (master) and the
// key-code consumer (slave). Transfer when EVT_VALID && EVT_READY.
interface touch_scan_ctrl_if;
  import touch_pkg::*;

  logic  EVT_VALID;
  logic  EVT_READY;
  code_t EVT_CODE;
  logic  EVT_RELEASE;

  modport master (output EVT_VALID, output EVT_CODE, output EVT_RELEASE, input EVT_READY);
  modport slave  (input EVT_VALID, input EVT_CODE, input EVT_RELEASE, output EVT_READY);
endinterface

// File: rtl/touch_scan_ctrl_debounce.sv
// touch_debounce: two-flop synchroniser followed by a per-vector debounce.
// stable only follows the synchronised pads after DEBOUNCE_CYCLES
// consecutive identical samples; stable_nxt is the value stable takes at
// the coming edge so the caller can register its outputs alongside it.
module touch_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] touch_in,
  output logic [3:0] stable,
  output logic [3:0] stable_nxt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync_p0;
  logic [3:0]       sync_p1;
  logic [3:0]       cand;
  logic [CNT_W-1:0] cnt;

  // Stable vector adopts the candidate once the run has been long enough.
  always_comb begin
    stable_nxt = stable;
    if (sync_p1 == cand && cnt == CNT_LAST)
      stable_nxt = cand;
  end

  // Synchroniser, candidate tracking and run-length counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      cand    <= '0;
      cnt     <= '0;
      stable  <= '0;
    end else begin
      sync_p0 <= touch_in;
      sync_p1 <= sync_p0;
      stable  <= stable_nxt;
      if (sync_p1 != cand) begin
        cand <= sync_p1;
        cnt  <= '0;
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/touch_scan_ctrl.sv
// touch_scan_ctrl: debounced 4-pad touch front-end. Tracks idle / single /
// multi touch, holds the decoded key code and emits press/release events
// through a 1-deep event register with a 1-entry pending slot (used for
// pad-to-pad slides) and a sticky overflow flag.
// Optional auto-repeat of held single touches: define TOUCH_REPEAT_EN.
module touch_scan_ctrl
  import touch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [3:0]                TOUCH_IN,
  output code_t                     TOUCH_OUT,
  output logic                      MULTI,
  touch_scan_ctrl_if.master         evt,
  output logic                      EVT_OVF,
  input  logic                      OVF_CLR
);

  if (DEBOUNCE_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES) ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_cfg_err
    $error("touch_scan_ctrl: invalid parameter set");
  end

  logic [3:0]   stable;
  logic [3:0]   stable_nxt;
  logic         chg;
  code_t        old_code;
  code_t        new_code;
  touch_state_e state_q;
  touch_state_e state_d;

  logic         fresh_v;
  code_t        fresh_code;
  logic         fresh_rel;
  logic         pend_set;
  logic         pend_v;
  code_t        pend_code;
  logic         rpt_fire;

  logic         new_v;
  code_t        new_code_sel;
  logic         new_rel;
  logic         ovf_set;

  logic         evt_valid_q;
  code_t        evt_code_q;
  logic         evt_rel_q;

  touch_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk        (CLK),
    .rst_n      (RST_N),
    .touch_in   (TOUCH_IN),
    .stable     (stable),
    .stable_nxt (stable_nxt)
  );

  assign chg      = (stable_nxt != stable);
  assign old_code = onehot_to_code(stable);
  assign new_code = onehot_to_code(stable_nxt);

`ifdef TOUCH_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic             stay;
  logic             rpt_first;
  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_lim;

  assign stay     = !chg && (state_q == ST_SINGLE);
  assign rpt_lim  = rpt_first ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1);
  assign rpt_fire = stay && (rpt_cnt == rpt_lim);

  // Hold-time counter: restarts on every entry into SINGLE, first repeat
  // after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
  always_ff @(posedge CLK) begin
    if (!RST_N || !stay) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
    end else begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // FSM next state and fresh event generation on stable-vector changes.
  always_comb begin
    state_d    = state_q;
    fresh_v    = 1'b0;
    fresh_code = CODE_NONE;
    fresh_rel  = 1'b0;
    pend_set   = 1'b0;
    if (chg) begin
      state_d = classify(stable_nxt);
      if (state_q == ST_SINGLE) begin
        fresh_v    = 1'b1;
        fresh_code = old_code;
        fresh_rel  = 1'b1;
        pend_set   = (state_d == ST_SINGLE);
      end else if (state_d == ST_SINGLE) begin
        fresh_v    = 1'b1;
        fresh_code = new_code;
      end
    end else if (rpt_fire) begin
      fresh_v    = 1'b1;
      fresh_code = old_code;
    end
  end

  // Event arbitration: a pending press goes first; a clash drops the fresh one.
  always_comb begin
    new_v        = pend_v | fresh_v;
    new_code_sel = pend_v ? pend_code : fresh_code;
    new_rel      = pend_v ? 1'b0 : fresh_rel;
    ovf_set      = (pend_v & fresh_v) |
                   (new_v & evt_valid_q & ~evt.EVT_READY);
  end

  // State, decoded outputs, pending slot, event register and overflow flag.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      TOUCH_OUT   <= CODE_NONE;
      MULTI       <= 1'b0;
      pend_v      <= 1'b0;
      pend_code   <= CODE_NONE;
      evt_valid_q <= 1'b0;
      evt_code_q  <= CODE_NONE;
      evt_rel_q   <= 1'b0;
      EVT_OVF     <= 1'b0;
    end else begin
      state_q   <= state_d;
      TOUCH_OUT <= new_code;
      MULTI     <= (classify(stable_nxt) == ST_MULTI);
      pend_v    <= pend_set;
      if (pend_set)
        pend_code <= new_code;
      if (new_v && (!evt_valid_q || evt.EVT_READY)) begin
        evt_valid_q <= 1'b1;
        evt_code_q  <= new_code_sel;
        evt_rel_q   <= new_rel;
      end else if (evt_valid_q && evt.EVT_READY) begin
        evt_valid_q <= 1'b0;
      end
      if (ovf_set)
        EVT_OVF <= 1'b1;
      else if (OVF_CLR)
        EVT_OVF <= 1'b0;
    end
  end

  assign evt.EVT_VALID   = evt_valid_q;
  assign evt.EVT_CODE    = evt_code_q;
  assign evt.EVT_RELEASE = evt_rel_q;

endmodule

// File: tb/tb_touch_scan_ctrl.sv
// Testbench for touch_scan_ctrl with DEBOUNCE_CYCLES=4: directed vector
// table, reset/repeat sequences and randomized pads checked every cycle
// against a behavioural model.
module tb_touch_scan_ctrl;
  import touch_pkg::*;

  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] TOUCH_IN = 4'b0;
  code_t      TOUCH_OUT;
  logic       MULTI;
  logic       EVT_OVF;
  logic       OVF_CLR = 1'b0;

  int checks = 0;
  int errors = 0;

  touch_scan_ctrl_if evt_if ();

  touch_scan_ctrl #(
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (3),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .TOUCH_IN  (TOUCH_IN),
    .TOUCH_OUT (TOUCH_OUT),
    .MULTI     (MULTI),
    .evt       (evt_if.master),
    .EVT_OVF   (EVT_OVF),
    .OVF_CLR   (OVF_CLR)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  logic [3:0] dly [2];
  logic [3:0] m_last;
  int         m_run;
  logic [3:0] m_stable;
  logic       m_valid;
  logic [3:0] m_code;
  logic       m_rel;
  logic       m_ovf;
  logic       m_pend_v;
  logic [3:0] m_pend_code;
  int         m_held;

  function automatic logic [3:0] pad_code(input logic [3:0] v);
    pad_code = 4'd0;
    if ($countones(v) == 1)
      for (int i = 0; i < 4; i++)
        if (v[i]) pad_code = 4'(i + 1);
  endfunction

  task automatic model_edge();
    logic [3:0] sample, nw, old;
    logic [3:0] ec [2];
    logic       er [2];
    int         n;
    logic       ovf_set;
    if (!RST_N) begin
      dly[0] = 0; dly[1] = 0; m_last = 0; m_run = 1; m_stable = 0;
      m_valid = 0; m_code = 0; m_rel = 0; m_ovf = 0;
      m_pend_v = 0; m_pend_code = 0; m_held = 0;
      return;
    end
    sample = dly[1];
    dly[1] = dly[0];
    dly[0] = TOUCH_IN;
    if (sample == m_last) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_last = sample;
      m_run  = 1;
    end
    old = m_stable;
    nw  = (m_run >= DC + 1) ? sample : m_stable;
    n = 0;
    if (m_pend_v) begin
      ec[n] = m_pend_code; er[n] = 1'b0; n++;
      m_pend_v = 1'b0;
    end
    if (nw != old) begin
      if ($countones(old) == 1) begin
        ec[n] = pad_code(old); er[n] = 1'b1; n++;
      end
      if ($countones(nw) == 1) begin
        if ($countones(old) == 1) begin
          m_pend_v = 1'b1; m_pend_code = pad_code(nw);
        end else begin
          ec[n] = pad_code(nw); er[n] = 1'b0; n++;
        end
      end
      m_held = 0;
    end else if ($countones(nw) == 1) begin
      m_held++;
`ifdef TOUCH_REPEAT_EN
      if (m_held == RD || (m_held > RD && (m_held - RD) % RP == 0)) begin
        ec[n] = pad_code(nw); er[n] = 1'b0; n++;
      end
`endif
    end
    m_stable = nw;
    ovf_set = (n > 1);
    if (n > 0) begin
      if (!m_valid || evt_if.EVT_READY) begin
        m_valid = 1'b1; m_code = ec[0]; m_rel = er[0];
      end else begin
        ovf_set = 1'b1;
      end
    end else if (m_valid && evt_if.EVT_READY) begin
      m_valid = 1'b0;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (OVF_CLR) m_ovf = 1'b0;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_vec();
    return {4'd0, TOUCH_OUT, MULTI, evt_if.EVT_VALID, EVT_OVF,
            evt_if.EVT_VALID ? evt_if.EVT_CODE : 4'd0,
            evt_if.EVT_VALID ? evt_if.EVT_RELEASE : 1'b0};
  endfunction

  function automatic logic [15:0] model_vec();
    return {4'd0, pad_code(m_stable), $countones(m_stable) > 1, m_valid, m_ovf,
            m_valid ? m_code : 4'd0, m_valid ? m_rel : 1'b0};
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    chk("model", dut_vec(), model_vec());
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] touch;
    logic       ready;
    logic       clr;
    int         n;
    logic [3:0] e_to;
    logic       e_multi;
    logic       e_valid;
    logic [3:0] e_code;
    logic       e_rel;
    logic       e_ovf;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(input logic [3:0] t, input logic r, input logic c, input int n,
                              input logic [3:0] to, input logic mu, input logic v,
                              input logic [3:0] cd, input logic rl, input logic ov);
    vec_t x;
    x.touch = t; x.ready = r; x.clr = c; x.n = n; x.e_to = to; x.e_multi = mu;
    x.e_valid = v; x.e_code = cd; x.e_rel = rl; x.e_ovf = ov;
    return x;
  endfunction

  initial begin
    int hold;
    logic [3:0] pat;
    // touch, ready, clr, n, TOUCH_OUT, MULTI, VALID, CODE, RELEASE, OVF
    vecs[0]  = mk(4'b0001, 0, 0, 6, 0, 0, 0, 0, 0, 0);  // not yet debounced
    vecs[1]  = mk(4'b0001, 0, 0, 1, 1, 0, 1, 1, 0, 0);  // edge 7: press 1
    vecs[2]  = mk(4'b0001, 1, 0, 1, 1, 0, 0, 0, 0, 0);  // transfer
    vecs[3]  = mk(4'b0000, 1, 0, 7, 0, 0, 1, 1, 1, 0);  // release 1
    vecs[4]  = mk(4'b0000, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(4'b0100, 1, 0, 3, 0, 0, 0, 0, 0, 0);  // 3-cycle glitch
    vecs[6]  = mk(4'b0000, 1, 0, 8, 0, 0, 0, 0, 0, 0);  // never reaches stable
    vecs[7]  = mk(4'b0010, 0, 0, 7, 2, 0, 1, 2, 0, 0);  // press 2
    vecs[8]  = mk(4'b0010, 1, 0, 1, 2, 0, 0, 0, 0, 0);
    vecs[9]  = mk(4'b0110, 0, 0, 7, 0, 1, 1, 2, 1, 0);  // release 2, multi
    vecs[10] = mk(4'b0110, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    vecs[11] = mk(4'b0000, 1, 0, 7, 0, 0, 0, 0, 0, 0);  // multi->idle, no event
    vecs[12] = mk(4'b0001, 0, 0, 7, 1, 0, 1, 1, 0, 0);  // press 1 held
    vecs[13] = mk(4'b0000, 0, 0, 7, 0, 0, 1, 1, 0, 1);  // release dropped
    vecs[14] = mk(4'b0000, 0, 1, 1, 0, 0, 1, 1, 0, 0);  // OVF_CLR
    vecs[15] = mk(4'b0000, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[16] = mk(4'b1000, 0, 0, 7, 4, 0, 1, 4, 0, 0);  // press 4
    vecs[17] = mk(4'b1000, 1, 0, 1, 4, 0, 0, 0, 0, 0);
    vecs[18] = mk(4'b0001, 1, 0, 7, 1, 0, 1, 4, 1, 0);  // slide: release 4
    vecs[19] = mk(4'b0001, 1, 0, 1, 1, 0, 1, 1, 0, 0);  // then press 1
    vecs[20] = mk(4'b0001, 1, 0, 1, 1, 0, 0, 0, 0, 0);

    evt_if.EVT_READY = 1'b0;
    RST_N = 1'b0;
    tick(); tick();
    chk("reset_state", dut_vec(), 16'h0000);
    chk("reset_code", {11'd0, evt_if.EVT_CODE, evt_if.EVT_RELEASE}, 16'h0000);
    RST_N = 1'b1;

    for (int i = 0; i < 21; i++) begin
      TOUCH_IN = vecs[i].touch;
      evt_if.EVT_READY = vecs[i].ready;
      OVF_CLR = vecs[i].clr;
      for (int k = 0; k < vecs[i].n; k++) tick();
      chk($sformatf("vec%0d", i), dut_vec(),
          {4'd0, vecs[i].e_to, vecs[i].e_multi, vecs[i].e_valid, vecs[i].e_ovf,
           vecs[i].e_code, vecs[i].e_rel});
    end
    OVF_CLR = 1'b0;

    // Reset in the middle of a debounce run: everything back to zero.
    TOUCH_IN = 4'b0010;
    tick(); tick(); tick(); tick();
    RST_N = 1'b0;
    tick();
    chk("mid_debounce_rst", dut_vec(), 16'h0000);
    chk("mid_rst_code", {11'd0, evt_if.EVT_CODE, evt_if.EVT_RELEASE}, 16'h0000);
    RST_N = 1'b1;
    TOUCH_IN = 4'b0000;
    for (int k = 0; k < 10; k++) tick();
    chk("post_rst_quiet", dut_vec(), 16'h0000);

    // Randomized pads, handshake stalls and overflow clears.
    for (int k = 0; k < 3000; ) begin
      pat = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) pat = 4'b0001 << $urandom_range(0, 3);
      hold = $urandom_range(1, 12);
      TOUCH_IN = pat;
      for (int j = 0; j < hold; j++) begin
        evt_if.EVT_READY = ($urandom_range(0, 9) < 7);
        OVF_CLR = ($urandom_range(0, 19) == 0);
        RST_N = ($urandom_range(0, 599) != 0);
        tick();
        k++;
      end
    end
    RST_N = 1'b1;
    OVF_CLR = 1'b0;

`ifdef TOUCH_REPEAT_EN
    // Held single touch auto-repeats at +10, +15, +20 after the press.
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    evt_if.EVT_READY = 1'b1;
    TOUCH_IN = 4'b0001;
    for (int k = 0; k < 7; k++) tick();
    chk("rpt_initial", {11'd0, evt_if.EVT_VALID, evt_if.EVT_CODE}, 16'h0011);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("rpt_k%0d", k),
          {10'd0, evt_if.EVT_VALID, evt_if.EVT_RELEASE,
           evt_if.EVT_VALID ? evt_if.EVT_CODE : 4'd0},
          (k == 10 || k == 15 || k == 20) ? 16'h0021 : 16'h0000);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
